mem_responder: RTL and testbench

Memory-side responder for the core's single-ported memory bus: the far end of `mem_addr`/`mem_rden`/`mem_wren`/`mem_size`/`memwrite_data`/`memread_data`. It holds a word-organised RAM with byte/half/word access and a small MMIO window containing a host-mailbox register and an optional cycle counter. Read data is registered, so it is valid in the cycle after the request. The core's own input latch then adds one more cycle before the data reaches its datapath.

---
 rtl/mem_responder_if.sv | 21 ++
 rtl/mem_responder.sv | 160 ++++++++++++++++
 tb/tb_mem_responder.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// mem_responder_if: single-ported memory bus between the core (master) and
// the memory-side responder (slave). Byte address, read/write strobes,
// access size, right-justified write data and registered read data.
interface mem_responder_if;
    logic [31:0] mem_addr;
    logic        mem_rden;
    logic        mem_wren;
    logic [1:0]  mem_size;
    logic [31:0] memwrite_data;
    logic [31:0] memread_data;

    modport master (
        output mem_addr, mem_rden, mem_wren, mem_size, memwrite_data,
        input  memread_data
    );

    modport slave (
        input  mem_addr, mem_rden, mem_wren, mem_size, memwrite_data,
        output memread_data
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the core's memory bus.
// Word-organised RAM with byte/half/word access, plus a 16-byte MMIO window
// holding a host mailbox (+0) and an optional free-running cycle counter (+4).
// Read data is registered (one cycle latency) and held between reads.
// Illegal accesses set a sticky err flag that only reset clears.
// Optional feature: define MEMRESP_CYCLE_CNTR_EN to build the cycle counter;
// without it, MMIO_BASE+4 reads 0 like +8/+C.
module mem_responder #(
    parameter int unsigned DEPTH     = 4096,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FFF0
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus,
    output logic            tohost_valid,
    output logic [31:0]     tohost_data,
    output logic            err
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    logic [31:0]   ram [DEPTH];

    size_e         size;
    logic [AW-1:0] word_idx;
    logic [1:0]    byte_off;
    logic          in_ram;
    logic          in_mmio;
    logic          misaligned;
    logic          bad;
    logic          legal;
    logic          ram_we;
    logic          ram_rd;
    logic          mbox_we;
    logic          mmio_rd;
    logic          oor_rd;
    logic [3:0]    lane_en;
    logic [31:0]   wr_word;
    logic [31:0]   shifted;
    logic [31:0]   ram_rd_data;
    logic [31:0]   mmio_rd_data;

`ifdef MEMRESP_CYCLE_CNTR_EN
    logic [31:0]   cycle_cnt;
`endif

    // Request decode: address region, alignment, error classification.
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        size       = size_e'(bus.mem_size);
        word_idx   = bus.mem_addr[AW+1:2];
        byte_off   = bus.mem_addr[1:0];
        in_ram     = (bus.mem_addr[31:AW+2] == '0);
        in_mmio    = (bus.mem_addr[31:4] == MMIO_BASE[31:4]);
        misaligned = 1'b0;
        case (size)
            SZ_HALF: misaligned = bus.mem_addr[0];
            SZ_WORD: misaligned = (bus.mem_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase

        bad = (bus.mem_rden || bus.mem_wren) &&
              ((bus.mem_rden && bus.mem_wren) ||
               (size == SZ_ILL) ||
               misaligned ||
               (in_mmio && size != SZ_WORD) ||
               (!in_ram && !in_mmio));
        legal = (bus.mem_rden || bus.mem_wren) && !bad;

        // A write still pending while reset is held is dropped.
        ram_we  = legal && bus.mem_wren && in_ram && rst;
        ram_rd  = legal && bus.mem_rden && in_ram;
        mbox_we = legal && bus.mem_wren && in_mmio && (bus.mem_addr[3:2] == 2'd0);
        mmio_rd = legal && bus.mem_rden && in_mmio;
        // Out-of-range reads clear the read data in addition to flagging err.
        oor_rd  = bus.mem_rden && !bus.mem_wren && !in_ram && !in_mmio;
    end

    // Write lane selection and read-data alignment for RAM and MMIO.
    always_comb begin
        lane_en = 4'b1111;
        wr_word = bus.memwrite_data;
        case (size)
            SZ_BYTE: begin
                lane_en = 4'b0001 << byte_off;
                wr_word = {4{bus.memwrite_data[7:0]}};
            end
            SZ_HALF: begin
                lane_en = 4'b0011 << {byte_off[1], 1'b0};
                wr_word = {2{bus.memwrite_data[15:0]}};
            end
            default: ;
        endcase

        shifted = ram[word_idx] >> {byte_off, 3'b000};
        case (size)
            SZ_BYTE: ram_rd_data = {24'd0, shifted[7:0]};
            SZ_HALF: ram_rd_data = {16'd0, shifted[15:0]};
            default: ram_rd_data = shifted;
        endcase

        case (bus.mem_addr[3:2])
            2'd0:    mmio_rd_data = tohost_data;
`ifdef MEMRESP_CYCLE_CNTR_EN
            2'd1:    mmio_rd_data = cycle_cnt;
`endif
            default: mmio_rd_data = '0;
        endcase
    end

    // RAM storage: byte-lane write committed at the sampling edge.
    // NOTE: the RAM array has no reset; contents survive reset and the block maps onto plain memory.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    ram[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end

    // Registered outputs: read data, mailbox, sticky error, cycle counter.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.memread_data <= '0;
            tohost_valid     <= 1'b0;
            tohost_data      <= '0;
            err              <= 1'b0;
`ifdef MEMRESP_CYCLE_CNTR_EN
            cycle_cnt        <= '0;
`endif
        end else begin
            tohost_valid <= mbox_we;
            if (mbox_we) begin
                tohost_data <= bus.memwrite_data;
            end
            if (bad) begin
                err <= 1'b1;
            end
            if (oor_rd) begin
                bus.memread_data <= '0;
            end else if (ram_rd) begin
                bus.memread_data <= ram_rd_data;
            end else if (mmio_rd) begin
                bus.memread_data <= mmio_rd_data;
            end
`ifdef MEMRESP_CYCLE_CNTR_EN
            cycle_cnt <= cycle_cnt + 32'd1;
`endif
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed test-plan steps followed by randomized traffic,
// all checked against a byte-array reference model of the responder.
`timescale 1ns/1ps
module tb_mem_responder;
    localparam int unsigned DEPTH     = 256;
    localparam int unsigned RAM_BYTES = 4 * DEPTH;
    localparam logic [31:0] MMIO_BASE = 32'hFFFF_FFF0;
`ifdef MEMRESP_CYCLE_CNTR_EN
    localparam bit          CNTR_EN   = 1'b1;
`else
    localparam bit          CNTR_EN   = 1'b0;
`endif
    localparam logic [31:0] EXP_CNT10 = CNTR_EN ? 32'd9 : 32'd0;

    logic        clk = 1'b0;
    logic        rst;
    logic        tohost_valid;
    logic [31:0] tohost_data;
    logic        err;

    mem_responder_if bus ();

    mem_responder #(.DEPTH(DEPTH), .MMIO_BASE(MMIO_BASE)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .tohost_valid (tohost_valid),
        .tohost_data  (tohost_data),
        .err          (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [7:0]  mdl_mem [RAM_BYTES];
    logic [31:0] exp_rd;
    logic [31:0] exp_th_data;
    logic        exp_th_valid;
    logic        exp_err;
    int unsigned edges_since_rel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_mmio_f(input logic [31:0] a);
        return (a >= MMIO_BASE) && ((a - MMIO_BASE) < 32'd16);
    endfunction

    task automatic drive_idle();
        bus.mem_rden      = 1'b0;
        bus.mem_wren      = 1'b0;
        bus.mem_size      = 2'd2;
        bus.mem_addr      = '0;
        bus.memwrite_data = '0;
    endtask

    // One bus cycle: drive request, clock it, update the model, compare outputs.
    task automatic step(input string tag, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int unsigned nbytes;
        int unsigned cnt_sample;
        bit in_ram;
        bit in_mmio;
        bit bad;
        bus.mem_rden      = rd;
        bus.mem_wren      = wr;
        bus.mem_size      = sz;
        bus.mem_addr      = a;
        bus.memwrite_data = d;
        nbytes     = 1 << sz;
        in_ram     = (a < RAM_BYTES);
        in_mmio    = in_mmio_f(a);
        bad        = (rd || wr) && ((rd && wr) || sz == 2'd3 || (a % nbytes) != 0 ||
                                    (in_mmio && sz != 2'd2) || (!in_ram && !in_mmio));
        cnt_sample = edges_since_rel;
        @(posedge clk);
        #1;
        edges_since_rel++;
        exp_th_valid = 1'b0;
        if (bad) begin
            exp_err = 1'b1;
            if (rd && !wr && !in_ram && !in_mmio) exp_rd = '0;
        end else if (rd) begin
            if (in_ram) begin
                exp_rd = '0;
                for (int i = 0; i < int'(nbytes); i++)
                    exp_rd = exp_rd | (32'(mdl_mem[int'(a) + i]) << (8 * i));
            end else begin
                case (a - MMIO_BASE)
                    32'd0:   exp_rd = exp_th_data;
                    32'd4:   exp_rd = CNTR_EN ? cnt_sample : 32'd0;
                    default: exp_rd = '0;
                endcase
            end
        end else if (wr) begin
            if (in_ram) begin
                for (int i = 0; i < int'(nbytes); i++)
                    mdl_mem[int'(a) + i] = d[8*i +: 8];
            end else if (a == MMIO_BASE) begin
                exp_th_data  = d;
                exp_th_valid = 1'b1;
            end
        end
        check({tag, ".rdata"}, bus.memread_data, exp_rd);
        check({tag, ".tvalid"}, 32'(tohost_valid), 32'(exp_th_valid));
        check({tag, ".tdata"}, tohost_data, exp_th_data);
        check({tag, ".err"}, 32'(err), 32'(exp_err));
    endtask

    // Assert reset between edges, confirm outputs clear at once, hold for
    // hold_edges rising edges, then release and return the bus to idle.
    task automatic pulse_reset(input int hold_edges);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst.rdata", bus.memread_data, 32'd0);
        check("rst.tvalid", 32'(tohost_valid), 32'd0);
        check("rst.tdata", tohost_data, 32'd0);
        check("rst.err", 32'(err), 32'd0);
        repeat (hold_edges) @(posedge clk);
        #1 rst = 1'b1;
        drive_idle();
        exp_rd          = '0;
        exp_th_data     = '0;
        exp_th_valid    = 1'b0;
        exp_err         = 1'b0;
        edges_since_rel = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int unsigned kind;
        int unsigned op;
        logic        r_rd;
        logic        r_wr;
        logic [1:0]  r_sz;
        logic [31:0] r_a;

        rst = 1'b0;
        drive_idle();
        exp_rd = '0; exp_th_data = '0; exp_th_valid = 1'b0; exp_err = 1'b0;
        edges_since_rel = 0;
        pulse_reset(2);

        // Cycle counter read on the 10th edge after reset release.
        for (int i = 0; i < 9; i++) step("idle", 1'b0, 1'b0, 2'd2, 32'd0, 32'd0);
        step("cntr", 1'b1, 1'b0, 2'd2, MMIO_BASE + 32'd4, 32'd0);
        check("cntr10", bus.memread_data, EXP_CNT10);

        // Word write then read-back on the following cycle.
        step("wr100", 1'b0, 1'b1, 2'd2, 32'h100, 32'hDEAD_BEEF);
        step("rd100", 1'b1, 1'b0, 2'd2, 32'h100, 32'd0);
        check("tp.word", bus.memread_data, 32'hDEAD_BEEF);

        // Byte write, then word/half/byte reads of the merged word.
        step("wrb102", 1'b0, 1'b1, 2'd0, 32'h102, 32'h0000_00AA);
        step("rdw100", 1'b1, 1'b0, 2'd2, 32'h100, 32'd0);
        check("tp.merge", bus.memread_data, 32'hDEAA_BEEF);
        step("rdh102", 1'b1, 1'b0, 2'd1, 32'h102, 32'd0);
        check("tp.half", bus.memread_data, 32'h0000_DEAA);
        step("rdb103", 1'b1, 1'b0, 2'd0, 32'h103, 32'd0);
        check("tp.byte", bus.memread_data, 32'h0000_00DE);

        // Mailbox write: single-cycle valid pulse, data held, readable.
        step("mbox", 1'b0, 1'b1, 2'd2, MMIO_BASE, 32'h1234_5678);
        check("tp.tvalid", 32'(tohost_valid), 32'd1);
        check("tp.tdata", tohost_data, 32'h1234_5678);
        step("mbox.idle", 1'b0, 1'b0, 2'd2, 32'd0, 32'd0);
        check("tp.tvalid_drop", 32'(tohost_valid), 32'd0);
        step("mbox.rd", 1'b1, 1'b0, 2'd2, MMIO_BASE, 32'd0);
        check("tp.mbox_rd", bus.memread_data, 32'h1234_5678);

        // Misaligned read and misaligned write: sticky err, RAM untouched.
        step("misrd", 1'b1, 1'b0, 2'd2, 32'h101, 32'd0);
        check("tp.err_set", 32'(err), 32'd1);
        step("miswr", 1'b0, 1'b1, 2'd1, 32'h103, 32'h0000_FFFF);
        step("chk100", 1'b1, 1'b0, 2'd2, 32'h100, 32'd0);
        check("tp.ram_kept", bus.memread_data, 32'hDEAA_BEEF);
        for (int i = 0; i < 3; i++) step("sticky", 1'b0, 1'b0, 2'd2, 32'd0, 32'd0);
        check("tp.err_sticky", 32'(err), 32'd1);

        // Read and write together, then asynchronous reset between edges.
        pulse_reset(0);
        step("both", 1'b1, 1'b1, 2'd2, 32'h100, 32'd0);
        check("tp.both_err", 32'(err), 32'd1);
        pulse_reset(0);
        step("both.rd", 1'b1, 1'b0, 2'd2, 32'h100, 32'd0);
        check("tp.both_kept", bus.memread_data, 32'hDEAA_BEEF);

        // A write sampled while reset is held must be dropped.
        bus.mem_rden = 1'b0; bus.mem_wren = 1'b1; bus.mem_size = 2'd2;
        bus.mem_addr = 32'h100; bus.memwrite_data = 32'h5555_5555;
        pulse_reset(1);
        step("disc.rd", 1'b1, 1'b0, 2'd2, 32'h100, 32'd0);
        check("tp.discard", bus.memread_data, 32'hDEAA_BEEF);

        // Back-to-back mailbox writes keep valid high and update data.
        step("mbox2a", 1'b0, 1'b1, 2'd2, MMIO_BASE, 32'h0000_00A1);
        step("mbox2b", 1'b0, 1'b1, 2'd2, MMIO_BASE, 32'h0000_00B2);
        check("b2b.tvalid", 32'(tohost_valid), 32'd1);
        check("b2b.tdata", tohost_data, 32'h0000_00B2);
        step("mbox2c", 1'b0, 1'b0, 2'd2, 32'd0, 32'd0);

        // Out-of-range read clears read data and flags err.
        step("oor.pre", 1'b1, 1'b0, 2'd2, 32'h100, 32'd0);
        step("oor", 1'b1, 1'b0, 2'd2, 32'h0000_2000, 32'd0);
        check("oor.rdata", bus.memread_data, 32'd0);
        check("oor.err", 32'(err), 32'd1);

        // Preload every RAM word so random reads have known contents.
        pulse_reset(0);
        for (int w = 0; w < int'(DEPTH); w++)
            step("pre", 1'b0, 1'b1, 2'd2, 32'(w * 4), $urandom);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 149) pulse_reset(0);
            kind = $urandom_range(0, 19);
            op   = $urandom_range(0, 9);
            r_rd = (op < 4) || (op == 8);
            r_wr = (op >= 4 && op < 8) || (op == 8);
            r_sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if (kind < 15)      r_a = 32'($urandom_range(0, RAM_BYTES - 1));
            else if (kind < 18) r_a = MMIO_BASE + 32'($urandom_range(0, 15));
            else                r_a = $urandom;
            if ($urandom_range(0, 4) != 0 && r_sz != 2'd3)
                r_a = r_a & ~((32'd1 << r_sz) - 32'd1);
            step("rnd", r_rd, r_wr, r_sz, r_a, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
